trace_capture_ctrl: RTL and testbench
=====================================

Name: trace_capture_ctrl

Overview:
Capture sequencer between the trace front end and the capture FIFO, clocked on fe_clk. Sequences arm, trigger qualification, post-trigger delay, bounded capture and stop. Gates FIFO writes from the trace event stream. Drives the arm/capturing status (LEDs), the trigger output pulse and sticky status for USB register readback.

Parameters:
pLEN_WIDTH, 32, width of capture-length limit and captured-word counter
pDELAY_WIDTH, 20, width of post-trigger delay count (fe_clk cycles)

Ports:
fe_clk  input  1  front-end clock; the only clock
reset  input  1  synchronous, active-high reset
I_arm  input  1  arm level from register; rising edge arms, falling edge disarms
I_trig_sel  input  2  trigger source: 0=m3_trig, 1=trace_match, 2=either, 3=immediate
I_m3_trig  input  1  target trigger, already synchronised to fe_clk
I_trace_match  input  1  pattern-matcher hit, fe_clk domain
I_trig_delay  input  pDELAY_WIDTH  cycles from trigger to capture start
I_capture_len  input  pLEN_WIDTH  FIFO words to capture; 0 = unlimited
I_data_valid  input  1  trace event word available this cycle
I_fifo_full  input  1  capture FIFO full
O_fifo_wr  output  1  FIFO write enable
O_armed  output  1  state is ARMED or DELAY
O_capturing  output  1  state is CAPTURING
O_trig_out  output  1  one-cycle pulse on entry to CAPTURING
O_done  output  1  sticky: capture completed
O_overflow  output  1  sticky: valid data dropped because FIFO full
O_words  output  pLEN_WIDTH  words written this capture, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; edge-detect registers cleared (arm_r=0, trig_r=0).
- States: IDLE, ARMED, DELAY, CAPTURING, DONE.
- Arm edges come from a registered copy arm_r. Trigger edge = selected source high while its registered copy was low.
- Arm rising edge, in IDLE or DONE:
  - go to ARMED next cycle;
  - clear O_done, O_overflow, O_words;
  - latch I_trig_sel, I_trig_delay, I_capture_len; config changes after this have no effect on the current capture.
- Arm falling edge, any state except DONE: go to IDLE. O_done stays 0. O_words/O_overflow hold their values.
- Arm falling edge in DONE: go to IDLE; O_done, O_overflow, O_words retained.
- A disarm edge outranks every other event in the same cycle.
- ARMED:
  - sel 3 triggers on the first ARMED cycle.
  - Other sels trigger on a qualified rising edge. An edge in the same cycle as the arm rising edge is not seen, because trig_r is sampled in IDLE.
  - On trigger at cycle T: delay=0 -> CAPTURING at T+1; delay=N -> DELAY, counter loaded with N, CAPTURING at T+1+N.
  - Further triggers during DELAY are ignored.
- O_trig_out is high exactly on the first CAPTURING cycle.
- CAPTURING:
  - O_fifo_wr = I_data_valid & ~I_fifo_full (combinational from state register).
  - Each write increments O_words; the counter saturates at all-ones.
  - If len≠0 and the write brings the count to len, go to DONE next cycle. That write is the last one; no write occurs in DONE.
  - If I_data_valid & I_fifo_full: O_overflow=1, no write, go to DONE next cycle.
  - If len=0, stop only on overflow or disarm.
- DONE: O_done=1; O_fifo_wr=0; hold until an arm edge.
- Reset asserted in any state returns to IDLE on the next edge. Status is cleared and no further writes occur.

Test Plan:
- Arm; sel=0, delay=0, len=4; m3_trig pulse at T; valid every cycle -> O_trig_out pulse at T+1; O_fifo_wr high T+1..T+4; O_done=1 at T+5; O_words=4.
- delay=10, sel=1, trace_match at T -> O_armed high through T+10; O_capturing rises at T+11; no writes before T+11.
- len=0, valid continuous, I_fifo_full asserted on 6th capture cycle -> 5 writes, O_overflow=1, O_done=1 next cycle, O_words=5.
- Disarm during DELAY, same cycle as a trigger -> IDLE next cycle; no O_trig_out, O_done=0, no writes.
- m3_trig high in the same cycle as the arm edge and held high -> no trigger; a fresh 0->1 edge later triggers. sel=3 -> capture starts 1 cycle after ARMED entry.
- Change I_capture_len 4->2 mid-capture; then reset mid-capture -> capture still ends at 4 words; after reset all outputs are 0 and O_fifo_wr stays 0.

Source files
------------

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: arm, trigger qualification, post-trigger delay,
// bounded capture into the trace FIFO, and sticky status for register readback.
`timescale 1ns/1ps
module trace_capture_ctrl #(
    parameter int pLEN_WIDTH   = 32,
    parameter int pDELAY_WIDTH = 20
) (
    input  logic                    fe_clk,
    input  logic                    reset,
    input  logic                    I_arm,
    input  logic [1:0]              I_trig_sel,
    input  logic                    I_m3_trig,
    input  logic                    I_trace_match,
    input  logic [pDELAY_WIDTH-1:0] I_trig_delay,
    input  logic [pLEN_WIDTH-1:0]   I_capture_len,
    input  logic                    I_data_valid,
    input  logic                    I_fifo_full,
    output logic                    O_fifo_wr,
    output logic                    O_armed,
    output logic                    O_capturing,
    output logic                    O_trig_out,
    output logic                    O_done,
    output logic                    O_overflow,
    output logic [pLEN_WIDTH-1:0]   O_words
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_DELAY = 3'd2;
    localparam logic [2:0] ST_CAPT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]              state;
    logic [2:0]              state_nx;
    logic                    arm_r;
    logic [1:0]              trig_r;
    logic [1:0]              sel_q;
    logic [pDELAY_WIDTH-1:0] delay_q;
    logic [pDELAY_WIDTH-1:0] dly_cnt;
    logic [pLEN_WIDTH-1:0]   len_q;
    logic [pLEN_WIDTH-1:0]   words_q;
    logic [pLEN_WIDTH-1:0]   words_inc;
    logic                    done_q;
    logic                    ovf_q;
    logic                    trig_out_q;

    logic arm_rise;
    logic arm_fall;
    logic src_now;
    logic src_prev;
    logic trig_hit;
    logic in_capt;
    logic fifo_wr;
    logic dropped;
    logic len_hit;
    logic idle_or_done;

    assign arm_rise     = I_arm & ~arm_r;
    assign arm_fall     = ~I_arm & arm_r;
    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);

    // trig_r holds the raw sources; the latched select picks which pair to edge-detect
    always_comb begin
        src_now  = 1'b0;
        src_prev = 1'b0;
        case (sel_q)
            2'd0: begin
                src_now  = I_m3_trig;
                src_prev = trig_r[0];
            end
            2'd1: begin
                src_now  = I_trace_match;
                src_prev = trig_r[1];
            end
            2'd2: begin
                src_now  = I_m3_trig | I_trace_match;
                src_prev = trig_r[0] | trig_r[1];
            end
            default: begin
                src_now  = 1'b0;
                src_prev = 1'b0;
            end
        endcase
    end

    assign trig_hit  = (sel_q == 2'd3) | (src_now & ~src_prev);
    assign in_capt   = (state == ST_CAPT);
    assign fifo_wr   = in_capt & I_data_valid & ~I_fifo_full;
    assign dropped   = in_capt & I_data_valid & I_fifo_full;
    assign words_inc = (words_q == '1) ? words_q : words_q + 1'b1;
    assign len_hit   = (len_q != '0) && (words_inc == len_q);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (arm_rise) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
                if (arm_fall)
                    state_nx = ST_IDLE;
                else if (trig_hit)
                    state_nx = (delay_q == '0) ? ST_CAPT : ST_DELAY;
            end
            ST_DELAY: begin
                if (arm_fall)
                    state_nx = ST_IDLE;
                else if (dly_cnt <= 1)
                    state_nx = ST_CAPT;
            end
            ST_CAPT: begin
                if (arm_fall)
                    state_nx = ST_IDLE;
                else if (dropped || (fifo_wr && len_hit))
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (arm_fall)
                    state_nx = ST_IDLE;
                else if (arm_rise)
                    state_nx = ST_ARMED;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge fe_clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            arm_r      <= 1'b0;
            trig_r     <= 2'b00;
            dly_cnt    <= '0;
            words_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            trig_out_q <= 1'b0;
        end else begin
            state      <= state_nx;
            arm_r      <= I_arm;
            trig_r     <= {I_trace_match, I_m3_trig};
            trig_out_q <= (state_nx == ST_CAPT) && (state != ST_CAPT);

            if (state == ST_ARMED)
                dly_cnt <= delay_q;
            else if (state == ST_DELAY)
                dly_cnt <= dly_cnt - 1'b1;

            if (idle_or_done && arm_rise) begin
                words_q <= '0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                if (fifo_wr) words_q <= words_inc;
                if (dropped) ovf_q   <= 1'b1;
                if (in_capt && state_nx == ST_DONE) done_q <= 1'b1;
            end
        end
    end

    // Capture configuration is frozen at arm time so register writes cannot disturb a capture
    always_ff @(posedge fe_clk) begin
        if (idle_or_done && arm_rise) begin
            sel_q   <= I_trig_sel;
            delay_q <= I_trig_delay;
            len_q   <= I_capture_len;
        end
    end

    assign O_fifo_wr   = fifo_wr;
    assign O_armed     = (state == ST_ARMED) || (state == ST_DELAY);
    assign O_capturing = in_capt;
    assign O_trig_out  = trig_out_q;
    assign O_done      = done_q;
    assign O_overflow  = ovf_q;
    assign O_words     = words_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timestamp-based model.
`timescale 1ns/1ps
module tb_trace_capture_ctrl;

    localparam int LW = 32;
    localparam int DW = 20;

    logic          fe_clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic          m3 = 1'b0;
    logic          mt = 1'b0;
    logic [DW-1:0] dly = '0;
    logic [LW-1:0] len = '0;
    logic          valid = 1'b0;
    logic          full = 1'b0;
    logic          fifo_wr, armed, capturing, trig_out, done, overflow;
    logic [LW-1:0] words;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    // Model state: waiting for a trigger, or triggered with capture starting at m_start
    bit            m_wait = 0, m_pend = 0, m_done = 0, m_ovf = 0;
    int            m_start = 0;
    logic [LW-1:0] m_words = '0, m_len = '0;
    logic [DW-1:0] m_dly = '0;
    logic [1:0]    m_sel = '0;
    bit            m_parm = 0, m_pm3 = 0, m_pmt = 0;

    trace_capture_ctrl #(.pLEN_WIDTH(LW), .pDELAY_WIDTH(DW)) dut (
        .fe_clk(fe_clk), .reset(reset), .I_arm(arm), .I_trig_sel(sel),
        .I_m3_trig(m3), .I_trace_match(mt), .I_trig_delay(dly),
        .I_capture_len(len), .I_data_valid(valid), .I_fifo_full(full),
        .O_fifo_wr(fifo_wr), .O_armed(armed), .O_capturing(capturing),
        .O_trig_out(trig_out), .O_done(done), .O_overflow(overflow),
        .O_words(words)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic cmp(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit src(input logic [1:0] s, input bit a, input bit b);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            default: return a | b;
        endcase
    endfunction

    always @(negedge fe_clk) begin
        bit e_cap, e_arm, e_to, e_wr, rise, fall, stop;
        if (chk_en) begin
            e_cap = m_pend && (cyc >= m_start);
            e_arm = m_wait || (m_pend && cyc < m_start);
            e_to  = m_pend && (cyc == m_start);
            e_wr  = e_cap && valid && !full;
            cmp("fifo_wr", LW'(fifo_wr), LW'(e_wr));
            cmp("armed", LW'(armed), LW'(e_arm));
            cmp("capturing", LW'(capturing), LW'(e_cap));
            cmp("trig_out", LW'(trig_out), LW'(e_to));
            cmp("done", LW'(done), LW'(m_done));
            cmp("overflow", LW'(overflow), LW'(m_ovf));
            cmp("words", words, m_words);

            if (reset) begin
                m_wait = 0; m_pend = 0; m_done = 0; m_ovf = 0; m_words = '0;
                m_parm = 0; m_pm3 = 0; m_pmt = 0;
            end else begin
                rise = arm && !m_parm;
                fall = !arm && m_parm;
                stop = 0;
                if (e_cap) begin
                    if (e_wr) begin
                        if (m_words != '1) m_words = m_words + 1;
                        if (m_len != 0 && m_words == m_len) stop = 1;
                    end
                    if (valid && full) begin
                        m_ovf = 1;
                        stop  = 1;
                    end
                end
                if (fall) begin
                    m_wait = 0;
                    m_pend = 0;
                end else if (rise) begin
                    m_wait = 1; m_done = 0; m_ovf = 0; m_words = '0;
                    m_sel = sel; m_dly = dly; m_len = len;
                end else if (m_wait) begin
                    if (m_sel == 2'd3 || (src(m_sel, m3, mt) && !src(m_sel, m_pm3, m_pmt))) begin
                        m_wait  = 0;
                        m_pend  = 1;
                        m_start = cyc + 1 + int'(m_dly);
                    end
                end else if (stop) begin
                    m_pend = 0;
                    m_done = 1;
                end
                m_parm = arm; m_pm3 = m3; m_pmt = mt;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        step(); reset = 1'b0;
        #3;
        cmp("rst_armed", LW'(armed), 0);
        cmp("rst_capturing", LW'(capturing), 0);
        cmp("rst_done", LW'(done), 0);
        cmp("rst_words", words, 0);
        cmp("rst_wr", LW'(fifo_wr), 0);

        // Basic capture: sel 0, no delay, 4 words
        step(); arm = 1; sel = 0; dly = 0; len = 4; valid = 1;
        step();
        step(); m3 = 1;
        #3; cmp("s1_armed", LW'(armed), 1); cmp("s1_trig_early", LW'(trig_out), 0);
        step(); m3 = 0;
        #3; cmp("s1_trig_out", LW'(trig_out), 1); cmp("s1_wr_first", LW'(fifo_wr), 1);
        hold(3);
        step();
        #3; cmp("s1_done", LW'(done), 1); cmp("s1_words", words, 4); cmp("s1_wr_done", LW'(fifo_wr), 0);
        step(); arm = 0;
        step();

        // Delay 10 on trace_match
        step(); arm = 1; sel = 1; dly = 10; len = 3;
        step();
        step(); mt = 1;
        step(); mt = 0;
        hold(9);
        #3; cmp("s2_armed_t10", LW'(armed), 1); cmp("s2_cap_t10", LW'(capturing), 0);
        step();
        #3; cmp("s2_cap_t11", LW'(capturing), 1); cmp("s2_trig_t11", LW'(trig_out), 1);
        hold(4); arm = 0;
        step();

        // Unlimited length, FIFO full on 6th capture cycle
        step(); arm = 1; sel = 3; dly = 0; len = 0;
        step();
        step();
        #3; cmp("s3_sel3_cap", LW'(capturing), 1);
        hold(4);
        step(); full = 1;
        #3; cmp("s3_wr_full", LW'(fifo_wr), 0);
        step(); full = 0;
        #3; cmp("s3_ovf", LW'(overflow), 1); cmp("s3_done", LW'(done), 1); cmp("s3_words", words, 5);
        step(); arm = 0;
        step();

        // Disarm during delay, coincident with a fresh trigger edge
        step(); arm = 1; sel = 0; dly = 5; len = 0;
        step();
        step(); m3 = 1;
        step(); m3 = 0;
        step(); m3 = 1; arm = 0;
        step(); m3 = 0;
        #3; cmp("s4_armed", LW'(armed), 0); cmp("s4_done", LW'(done), 0); cmp("s4_words", words, 0);
        hold(8);

        // Trigger held high across the arm edge is not a trigger
        step(); arm = 1; m3 = 1; sel = 0; dly = 0; len = 2;
        hold(3);
        #3; cmp("s5_armed", LW'(armed), 1); cmp("s5_cap", LW'(capturing), 0);
        step(); m3 = 0;
        step(); m3 = 1;
        step();
        #3; cmp("s5_cap_edge", LW'(capturing), 1);
        hold(3); arm = 0; m3 = 0;
        step();

        // Length change mid-capture is ignored; then reset mid-capture
        step(); arm = 1; sel = 3; dly = 0; len = 4;
        step();
        step(); len = 2;
        step();
        step();
        #3; cmp("s6_cap_w3", LW'(capturing), 1);
        step();
        step();
        #3; cmp("s6_done", LW'(done), 1); cmp("s6_words", words, 4);
        step(); arm = 0;
        step();
        step(); arm = 1;
        step();
        step();
        step(); reset = 1; arm = 0;
        step(); reset = 0;
        #3; cmp("s6_rst_cap", LW'(capturing), 0); cmp("s6_rst_wr", LW'(fifo_wr), 0); cmp("s6_rst_words", words, 0);
        hold(3);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) arm = ~arm;
            sel   = 2'($urandom_range(0, 3));
            dly   = DW'($urandom_range(0, 6));
            len   = LW'($urandom_range(0, 8));
            m3    = ($urandom_range(0, 7) == 0);
            mt    = ($urandom_range(0, 7) == 0);
            valid = ($urandom_range(0, 3) != 0);
            full  = ($urandom_range(0, 9) == 0);
        end
        step(); reset = 0;
        step();
        @(posedge fe_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
